mem_access_stage: RTL

- Memory-access stage of the pipelined CPU, sitting directly upstream of the register file.
- Accepts one EX-stage result per transaction and runs a req/ack handshake with data memory for loads and stores.
- Performs byte/half/word lane alignment and sign/zero extension.
- Drives the register-file write port (Rv, RegWr, busV) from registered state only.

---
 rtl/mem_access_stage_if.sv | 48 ++++
 rtl/mem_access_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: groups the EX-result handshake, the data-memory
// req/ack port and the register-file write port of the memory-access stage.
// The slave modport is the stage's own view. The master modport is the view
// of the surrounding pipeline and memory.
interface mem_access_stage_if #(
  parameter int N = 32
);
  // EX-stage side
  logic         InValid;
  logic         InReady;
  logic         MemRd;
  logic         MemWr;
  logic         RegWrIn;
  logic [1:0]   Size;
  logic         Unsigned;
  logic [N-1:0] Addr;
  logic [N-1:0] StoreData;
  logic [N-1:0] AluResult;
  logic [4:0]   RvIn;
  // data-memory side
  logic         dReq;
  logic         dWe;
  logic [N-1:0] dAddr;
  logic [N-1:0] dWData;
  logic [3:0]   dBe;
  logic         dAck;
  logic [N-1:0] dRData;
  // register-file side
  logic [4:0]   Rv;
  logic         RegWr;
  logic [N-1:0] busV;
  logic         WbValid;
  logic         Misalign;

  modport slave (
    input  InValid, MemRd, MemWr, RegWrIn, Size, Unsigned, Addr, StoreData,
           AluResult, RvIn, dAck, dRData,
    output InReady, dReq, dWe, dAddr, dWData, dBe, Rv, RegWr, busV, WbValid,
           Misalign
  );

  modport master (
    output InValid, MemRd, MemWr, RegWrIn, Size, Unsigned, Addr, StoreData,
           AluResult, RvIn, dAck, dRData,
    input  InReady, dReq, dWe, dAddr, dWData, dBe, Rv, RegWr, busV, WbValid,
           Misalign
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access stage of the pipelined CPU.
// It accepts one EX result per transaction. ALU results retire after one
// cycle. Loads and stores run a req/ack handshake with data memory and
// retire on dAck. The stage aligns store lanes and extracts and extends load
// data. Every output except InReady comes from a flop, so the register-file
// write port stays stable across the negedge write.
// Optional feature: define MEM_ALIGN_CHECK_EN to turn misaligned half and word
// accesses into a one-cycle Misalign retirement with no memory request.
// Without the macro, Misalign is always 0 and unusable low address bits are
// ignored.
module mem_access_stage #(
  parameter int N = 32
) (
  input logic               Clock,
  input logic               Reset_n,
  mem_access_stage_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t       state_r, state_nxt_s;

  // registered memory-port and writeback outputs
  logic         dreq_r, dreq_nxt_s;
  logic         dwe_r, dwe_nxt_s;
  logic [N-1:0] daddr_r, daddr_nxt_s;
  logic [N-1:0] dwdata_r, dwdata_nxt_s;
  logic [3:0]   dbe_r, dbe_nxt_s;
  logic [4:0]   rv_r, rv_nxt_s;
  logic         regwr_r, regwr_nxt_s;
  logic [N-1:0] busv_r, busv_nxt_s;
  logic         wbvalid_r, wbvalid_nxt_s;
  logic         misalign_r, misalign_nxt_s;

  // transaction context held while the memory access is outstanding
  logic         is_store_r, is_store_nxt_s;
  logic [1:0]   size_r, size_nxt_s;
  logic [1:0]   addr_lo_r, addr_lo_nxt_s;
  logic         unsigned_r, unsigned_nxt_s;
  logic         regwr_pend_r, regwr_pend_nxt_s;
  logic [4:0]   rv_pend_r, rv_pend_nxt_s;

  logic         mem_op_s;
  logic         regwr_ok_s;
  logic         misaligned_s;

  // Byte enables for a store. Size 11 is handled as a word.
  function automatic logic [3:0] store_be(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store value across the lanes it may land in.
  function automatic logic [N-1:0] store_wdata(input logic [1:0]   size,
                                               input logic [N-1:0] sd);
    logic [N-1:0] wd;
    case (size)
      2'b00:   wd = {(N/8){sd[7:0]}};
      2'b01:   wd = {(N/16){sd[15:0]}};
      default: wd = sd;
    endcase
    return wd;
  endfunction

  // Shift the addressed lane down, then sign- or zero-extend it.
  function automatic logic [N-1:0] load_extract(input logic [N-1:0] rd,
                                                input logic [1:0]   size,
                                                input logic [1:0]   addr_lo,
                                                input logic         uns);
    logic [N-1:0] sh;
    logic [N-1:0] val;
    case (size)
      2'b00: begin
        sh  = rd >> {addr_lo, 3'b000};
        val = uns ? {{(N-8){1'b0}}, sh[7:0]} : {{(N-8){sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh  = rd >> {addr_lo[1], 4'b0000};
        val = uns ? {{(N-16){1'b0}}, sh[15:0]} : {{(N-16){sh[15]}}, sh[15:0]};
      end
      default: begin
        sh  = rd;
        val = sh;
      end
    endcase
    return val;
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  // A half must be 2-byte aligned. A word (size 10 or 11) must be 4-byte aligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

  assign misaligned_s = is_misaligned(bus.Size, bus.Addr[1:0]);
`else
  assign misaligned_s = 1'b0;
`endif

  assign mem_op_s   = bus.MemRd | bus.MemWr;
  assign regwr_ok_s = bus.RegWrIn & (bus.RvIn != 5'd0);

  // State register and registered outputs. The async reset drops dReq at once.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r      <= ST_IDLE;
      dreq_r       <= 1'b0;
      dwe_r        <= 1'b0;
      daddr_r      <= {N{1'b0}};
      dwdata_r     <= {N{1'b0}};
      dbe_r        <= 4'b0000;
      rv_r         <= 5'd0;
      regwr_r      <= 1'b0;
      busv_r       <= {N{1'b0}};
      wbvalid_r    <= 1'b0;
      misalign_r   <= 1'b0;
      is_store_r   <= 1'b0;
      size_r       <= 2'b00;
      addr_lo_r    <= 2'b00;
      unsigned_r   <= 1'b0;
      regwr_pend_r <= 1'b0;
      rv_pend_r    <= 5'd0;
    end else begin
      state_r      <= state_nxt_s;
      dreq_r       <= dreq_nxt_s;
      dwe_r        <= dwe_nxt_s;
      daddr_r      <= daddr_nxt_s;
      dwdata_r     <= dwdata_nxt_s;
      dbe_r        <= dbe_nxt_s;
      rv_r         <= rv_nxt_s;
      regwr_r      <= regwr_nxt_s;
      busv_r       <= busv_nxt_s;
      wbvalid_r    <= wbvalid_nxt_s;
      misalign_r   <= misalign_nxt_s;
      is_store_r   <= is_store_nxt_s;
      size_r       <= size_nxt_s;
      addr_lo_r    <= addr_lo_nxt_s;
      unsigned_r   <= unsigned_nxt_s;
      regwr_pend_r <= regwr_pend_nxt_s;
      rv_pend_r    <= rv_pend_nxt_s;
    end
  end

  // Next state and next output values. WbValid, RegWr and Misalign default to
  // 0 so they pulse for one cycle.
  always_comb begin
    state_nxt_s      = state_r;
    dreq_nxt_s       = dreq_r;
    dwe_nxt_s        = dwe_r;
    daddr_nxt_s      = daddr_r;
    dwdata_nxt_s     = dwdata_r;
    dbe_nxt_s        = dbe_r;
    rv_nxt_s         = rv_r;
    busv_nxt_s       = busv_r;
    regwr_nxt_s      = 1'b0;
    wbvalid_nxt_s    = 1'b0;
    misalign_nxt_s   = 1'b0;
    is_store_nxt_s   = is_store_r;
    size_nxt_s       = size_r;
    addr_lo_nxt_s    = addr_lo_r;
    unsigned_nxt_s   = unsigned_r;
    regwr_pend_nxt_s = regwr_pend_r;
    rv_pend_nxt_s    = rv_pend_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.InValid) begin
          if (mem_op_s) begin
            if (misaligned_s) begin
              // rejected without touching memory; retires like an ALU op
              wbvalid_nxt_s  = 1'b1;
              misalign_nxt_s = 1'b1;
              busv_nxt_s     = {N{1'b0}};
              rv_nxt_s       = bus.RvIn;
            end else begin
              is_store_nxt_s   = bus.MemWr;
              size_nxt_s       = bus.Size;
              addr_lo_nxt_s    = bus.Addr[1:0];
              unsigned_nxt_s   = bus.Unsigned;
              regwr_pend_nxt_s = regwr_ok_s;
              rv_pend_nxt_s    = bus.RvIn;
              dreq_nxt_s       = 1'b1;
              dwe_nxt_s        = bus.MemWr;
              daddr_nxt_s      = {bus.Addr[N-1:2], 2'b00};
              dbe_nxt_s        = bus.MemWr ? store_be(bus.Size, bus.Addr[1:0]) : 4'b1111;
              dwdata_nxt_s     = bus.MemWr ? store_wdata(bus.Size, bus.StoreData) : {N{1'b0}};
              state_nxt_s      = ST_ACCESS;
            end
          end else begin
            busv_nxt_s    = bus.AluResult;
            rv_nxt_s      = bus.RvIn;
            regwr_nxt_s   = regwr_ok_s;
            wbvalid_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        if (bus.dAck) begin
          dreq_nxt_s    = 1'b0;
          dwe_nxt_s     = 1'b0;
          wbvalid_nxt_s = 1'b1;
          rv_nxt_s      = rv_pend_r;
          state_nxt_s   = ST_IDLE;
          if (is_store_r) begin
            regwr_nxt_s = 1'b0;
            busv_nxt_s  = {N{1'b0}};
          end else begin
            regwr_nxt_s = regwr_pend_r;
            busv_nxt_s  = load_extract(bus.dRData, size_r, addr_lo_r, unsigned_r);
          end
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
        dreq_nxt_s  = 1'b0;
        dwe_nxt_s   = 1'b0;
      end
    endcase
  end

  assign bus.InReady  = (state_r == ST_IDLE);
  assign bus.dReq     = dreq_r;
  assign bus.dWe      = dwe_r;
  assign bus.dAddr    = daddr_r;
  assign bus.dWData   = dwdata_r;
  assign bus.dBe      = dbe_r;
  assign bus.Rv       = rv_r;
  assign bus.RegWr    = regwr_r;
  assign bus.busV     = busv_r;
  assign bus.WbValid  = wbvalid_r;
  assign bus.Misalign = misalign_r;

endmodule
